data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data RAM for the RISC-V core's load/store path, located between the datapath's ALU result (address) and the write-back mux (read data).
- Byte-addressed interface on 32-bit words.
- Synchronous write on the rising edge of clk when we=1; combinational (asynchronous) read.
- Full-word accesses only; byte/halfword lane handling is outside this block.

Parameters:
- DEPTH, 1024: number of 32-bit words. Power of two, 2..65536. IDX_W = $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable; sampled at the rising edge of clk.
- a  input  32  byte address.
- wd  input  32  write data.
- rd  output  32  read data; combinational function of a and the array contents.

Behaviour:
- Storage: array mem[0..DEPTH-1] of 32-bit words.
- Word index: idx = a[IDX_W+1:2].
  - a[1:0] are ignored, so A=8, 9, 10 and 11 all select word 2 (no misalignment trap).
  - Address bits above IDX_W+1 are ignored; addresses wrap modulo DEPTH*4 bytes (A=DEPTH*4 aliases word 0).
- Read path:
  - rd = mem[idx] continuously; no clock involved and zero cycles of latency.
  - rd must update within the same delta/settle time after a or mem changes (e.g. a 1 ns delay after changing a is sufficient).
- Write:
  - At a rising edge of clk with rst=0 and we=1: mem[idx] <= wd.
  - With we=0, mem is unchanged regardless of wd and a.
- Read-during-write (same idx):
  - Before the edge, rd shows the old word.
  - After the edge, rd shows wd (follows from the combinational read).
  - No write-through bypass before the edge.
- Reset:
  - At a rising edge with rst=1, every word of mem is cleared to 32'h0000_0000 in that single cycle.
  - rd therefore reads 0 at any address immediately after.
  - rst has priority over we; a write requested in the same cycle as rst is discarded.
  - rst asserted mid-sequence wipes all previously written data.
- Power-up before the first reset: contents undefined (X in simulation). Benches must reset first.
- we, a and wd are sampled only at the rising edge; glitches between edges do not affect contents.
- No output registers. rd has no reset value of its own: it equals mem[idx], which is 0 after reset.

Test Plan:
- Reset: hold rst=1 for one edge, then rst=0; read a=0, 4 and 4092 -> rd=0000_0000 each.
- Basic write/read: at negedge set a=0, wd=DEADBEEF, we=1; posedge; negedge we=0 -> rd=DEADBEEF. Then write a=4, wd=CAFEBABE -> rd=CAFEBABE; set a=0, wait 1 ns -> rd=DEADBEEF (no corruption of word 0).
- Write-enable guard: a=4, wd=FFFFFFFF, we=0, one posedge -> rd remains CAFEBABE.
- Byte aliasing and wrap:
  - Write 12345678 at a=8; reads at a=9, 10 and 11 -> 12345678.
  - With DEPTH=1024, write A5A5A5A5 at a=4096 -> read at a=0 returns A5A5A5A5.
- Reset priority and mid-run reset: a=8, wd=0BADF00D, we=1, rst=1 on the same edge -> afterwards a=8 reads 0000_0000 and a=4 reads 0000_0000.
- Read-during-write timing:
  - a=12 holding 11111111; set we=1, wd=22222222 -> rd=11111111 before the posedge and 22222222 after it.
  - Back-to-back writes on consecutive edges to a=12 then a=16 both land.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: word-organised data RAM for the load/store path.
// Byte-addressed, full-word accesses, synchronous write, combinational read.
// A synchronous reset clears every word in a single cycle and has priority over writes.
module data_memory #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;

    // Byte offset and address bits above the array size are dropped, so
    // addresses alias within a word and wrap modulo DEPTH*4 bytes.
    assign idx = a[IDX_W+1:2];

    logic unused_a_bits;
    assign unused_a_bits = ^{a[31:IDX_W+2], a[1:0]};

    // Storage update: reset wipes the whole array; otherwise write on we.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            mem_q[idx] <= wd;
        end
    end

    // Asynchronous read; no bypass, so a same-word write shows only after the edge.
    always_comb begin
        rd = mem_q[idx];
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed test plan followed by randomized traffic, all checked
// against a word-array reference model indexed by (address / 4) mod DEPTH.
module tb_data_memory;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_checks;
    int n_pass;

    logic [31:0] model [DEPTH];

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Drive one clock cycle from the negedge, then apply the model's view of that edge.
    task automatic cycle(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        rst = r;
        we  = w;
        a   = addr;
        wd  = data;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        end else if (w) begin
            model[widx(addr)] = data;
        end
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr);
        a = addr;
        #1;
        check(tag, rd, model[widx(addr)]);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        we  = 1'b0;
        a   = 32'h0;
        wd  = 32'h0;

        // Reset
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        a = 32'd0;    #1; check("reset_a0",    rd, 32'h0000_0000);
        a = 32'd4;    #1; check("reset_a4",    rd, 32'h0000_0000);
        a = 32'd4092; #1; check("reset_a4092", rd, 32'h0000_0000);

        // Basic write/read
        cycle(1'b0, 1'b1, 32'd0, 32'hDEAD_BEEF);
        a = 32'd0; #1; check("wr_a0", rd, 32'hDEAD_BEEF);
        cycle(1'b0, 1'b1, 32'd4, 32'hCAFE_BABE);
        a = 32'd4; #1; check("wr_a4", rd, 32'hCAFE_BABE);
        a = 32'd0; #1; check("a0_intact", rd, 32'hDEAD_BEEF);

        // Write-enable guard
        cycle(1'b0, 1'b0, 32'd4, 32'hFFFF_FFFF);
        a = 32'd4; #1; check("we_guard", rd, 32'hCAFE_BABE);

        // Byte aliasing and wrap
        cycle(1'b0, 1'b1, 32'd8, 32'h1234_5678);
        a = 32'd9;  #1; check("alias_a9",  rd, 32'h1234_5678);
        a = 32'd10; #1; check("alias_a10", rd, 32'h1234_5678);
        a = 32'd11; #1; check("alias_a11", rd, 32'h1234_5678);
        cycle(1'b0, 1'b1, 32'd4096, 32'hA5A5_A5A5);
        a = 32'd0; #1; check("wrap_a0", rd, 32'hA5A5_A5A5);

        // Reset priority over a same-cycle write, and wipe of earlier data
        cycle(1'b1, 1'b1, 32'd8, 32'h0BAD_F00D);
        a = 32'd8; #1; check("rstprio_a8", rd, 32'h0000_0000);
        a = 32'd4; #1; check("rstwipe_a4", rd, 32'h0000_0000);
        a = 32'd0; #1; check("rstwipe_a0", rd, 32'h0000_0000);

        // Read-during-write timing
        cycle(1'b0, 1'b1, 32'd12, 32'h1111_1111);
        @(negedge clk);
        a  = 32'd12;
        wd = 32'h2222_2222;
        we = 1'b1;
        #1; check("rdw_before", rd, 32'h1111_1111);
        @(posedge clk);
        model[3] = 32'h2222_2222;
        #1; check("rdw_after", rd, 32'h2222_2222);

        // Back-to-back writes on consecutive edges
        @(negedge clk);
        a  = 32'd12;
        wd = 32'h3333_3333;
        we = 1'b1;
        @(posedge clk);
        model[3] = 32'h3333_3333;
        @(negedge clk);
        a  = 32'd16;
        wd = 32'h4444_4444;
        @(posedge clk);
        model[4] = 32'h4444_4444;
        @(negedge clk);
        we = 1'b0;
        a = 32'd12; #1; check("b2b_a12", rd, 32'h3333_3333);
        a = 32'd16; #1; check("b2b_a16", rd, 32'h4444_4444);

        // Randomized traffic against the model
        for (int it = 0; it < 600; it++) begin
            logic        r;
            logic        w;
            logic [31:0] addr;
            logic [31:0] data;
            r    = ($urandom_range(0, 59) == 0);
            w    = ($urandom_range(0, 2) != 0);
            addr = ($urandom_range(0, 1) == 0) ? $urandom : {20'h0, 12'($urandom_range(0, 255))};
            data = $urandom;
            @(negedge clk);
            rst = r;
            we  = w;
            a   = addr;
            wd  = data;
            #1; check("rnd_pre_edge", rd, model[widx(addr)]);
            @(posedge clk);
            if (r) begin
                for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
            end else if (w) begin
                model[widx(addr)] = data;
            end
            #1; check("rnd_post_edge", rd, model[widx(addr)]);
            @(negedge clk);
            rst = 1'b0;
            we  = 1'b0;
            read_check("rnd_read", ($urandom_range(0, 1) == 0) ? $urandom : {20'h0, 12'($urandom_range(0, 255))});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
